sum_feeder: RTL and testbench

SUM_FEEDER -- requirements
Module: sum_feeder

---
 rtl/sum_feeder_if.sv | 24 ++
 rtl/sum_feeder.sv | 104 ++++++++++
 tb/tb_sum_feeder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sum_feeder_if.sv
// Bus bundle between sum_feeder and its producer/summer side.
// Strobes push_l/start_l are one-cycle active-low requests with no ready; a request is taken or dropped in the cycle it is seen.
interface sum_feeder_if;
  logic       push_l;
  logic [7:0] din;
  logic       start_l;
  logic       done_in;
  logic       go_l;
  logic [7:0] inA;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       busy;

  modport master (
    output push_l, din, start_l, done_in,
    input  go_l, inA, count, full, empty, busy
  );

  modport slave (
    input  push_l, din, start_l, done_in,
    output go_l, inA, count, full, empty, busy
  );
endinterface

// File: rtl/sum_feeder.sv
// 8x8 FIFO that feeds a downstream summer one operand per cycle (IDLE/FEED/TERM).
// Optional macro SUM_FEEDER_ZERO_DROP_EN discards zero-valued pushes.
module sum_feeder (
  input  logic              ck,
  input  logic              reset_l,
  sum_feeder_if.slave       bus,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FEED = 2'd1;
  localparam logic [1:0] S_TERM = 2'd2;

  logic [1:0] state_q, state_d;
  logic       first_cyc_q, first_cyc_d;
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d;
  logic [7:0] mem_q [8];
  logic [7:0] mem_d [8];
  logic       zero_ok;

`ifdef SUM_FEEDER_ZERO_DROP_EN
  // A zero would look like end-of-stream to the summer, so it never enters.
  assign zero_ok = (bus.din != 8'd0);
`else
  assign zero_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    first_cyc_d = first_cyc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_d       = mem_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.start_l && (count_q != 4'd0)) begin
          state_d     = S_FEED;
          first_cyc_d = 1'b1;
        end else if (!bus.push_l && bus.start_l && (count_q != 4'd8) && zero_ok) begin
          mem_d[wr_ptr_q] = bus.din;
          wr_ptr_d        = wr_ptr_q + 3'd1;
          count_d         = count_q + 4'd1;
        end
      end
      S_FEED: begin
        first_cyc_d = 1'b0;
        // The summer saw a zero operand after the first: abandon the rest.
        if (!first_cyc_q && bus.done_in) begin
          state_d  = S_IDLE;
          rd_ptr_d = 3'd0;
          wr_ptr_d = 3'd0;
          count_d  = 4'd0;
        end else begin
          rd_ptr_d = rd_ptr_q + 3'd1;
          count_d  = count_q - 4'd1;
          if (count_q == 4'd1) begin
            state_d = S_TERM;
          end
        end
      end
      S_TERM: begin
        if (bus.done_in) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= S_IDLE;
      first_cyc_q <= 1'b0;
      wr_ptr_q    <= 3'd0;
      rd_ptr_q    <= 3'd0;
      count_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      first_cyc_q <= first_cyc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage is not reset; the cleared pointers and count make old data unreachable.
  always_ff @(posedge ck) begin
    mem_q <= mem_d;
  end

  assign bus.go_l   = !((state_q == S_FEED) && first_cyc_q);
  assign bus.inA    = (state_q == S_FEED) ? mem_q[rd_ptr_q] : 8'd0;
  assign bus.count  = count_q;
  assign bus.full   = (count_q == 4'd8);
  assign bus.empty  = (count_q == 4'd0);
  assign bus.busy   = (state_q != S_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sum_feeder.sv
// Randomized bench for sum_feeder: queue-based reference model plus a behavioural summer.
module tb_sum_feeder;
  logic       ck;
  logic       reset_l;
  logic [1:0] state_dbg;
  int         checks;
  int         failures;
  logic [7:0] model_q[$];

  // Behavioural summer: loads on go_l, accumulates, done when a zero operand arrives.
  logic [7:0] sum_acc;
  logic       sum_run;

  sum_feeder_if sif();

  sum_feeder dut (
    .ck        (ck),
    .reset_l   (reset_l),
    .bus       (sif.slave),
    .state_dbg (state_dbg)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  assign sif.done_in = sum_run && (sif.inA == 8'd0);

  always @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      sum_acc <= 8'd0;
      sum_run <= 1'b0;
    end else if (!sif.go_l) begin
      sum_acc <= sif.inA;
      sum_run <= 1'b1;
    end else if (sum_run) begin
      if (sif.done_in) sum_run <= 1'b0;
      else             sum_acc <= sum_acc + sif.inA;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(sif.busy), 32'd0);
    chk({tag, "_go_l"}, 32'(sif.go_l), 32'd1);
    chk({tag, "_inA"},  32'(sif.inA),  32'd0);
  endtask

  task automatic do_push(input logic [7:0] v);
    @(negedge ck);
    sif.push_l = 1'b0;
    sif.din    = v;
    @(negedge ck);
    sif.push_l = 1'b1;
`ifdef SUM_FEEDER_ZERO_DROP_EN
    if (model_q.size() < 8 && v != 8'd0) model_q.push_back(v);
`else
    if (model_q.size() < 8) model_q.push_back(v);
`endif
    chk("push_count", 32'(sif.count), 32'(model_q.size()));
    chk("push_full",  32'(sif.full),  32'(model_q.size() == 8));
    chk("push_empty", 32'(sif.empty), 32'(model_q.size() == 0));
  endtask

  // Start a feed; with noise, push/start strobes are also driven while busy and must be ignored.
  task automatic run_feed(input bit noise);
    int         n;
    logic [7:0] esum;
    n    = model_q.size();
    esum = 8'd0;
    @(negedge ck);
    sif.start_l = 1'b0;
    if (n > 0 && noise) begin
      sif.push_l = 1'b0;
      sif.din    = 8'($urandom_range(1, 255));
    end
    @(negedge ck);
    sif.start_l = 1'b1;
    sif.push_l  = 1'b1;
    if (n == 0) begin
      for (int k = 0; k < 3; k++) begin
        chk_idle("empty_start");
        chk("empty_start_count", 32'(sif.count), 32'd0);
        @(negedge ck);
      end
      return;
    end
    for (int i = 0; i < n; i++) begin
      chk("feed_busy", 32'(sif.busy), 32'd1);
      chk("feed_go_l", 32'(sif.go_l), (i == 0) ? 32'd0 : 32'd1);
      chk("feed_inA",  32'(sif.inA),  32'(model_q[i]));
      esum = esum + model_q[i];
      if (i > 0 && model_q[i] == 8'd0) begin
        sif.push_l  = 1'b1;
        sif.start_l = 1'b1;
        @(negedge ck);
        chk_idle("flush");
        chk("flush_count", 32'(sif.count), 32'd0);
        chk("flush_empty", 32'(sif.empty), 32'd1);
        model_q.delete();
        return;
      end
      if (noise) begin
        sif.push_l  = 1'b0;
        sif.din     = 8'($urandom_range(1, 255));
        sif.start_l = 1'($urandom_range(0, 1));
      end
      @(negedge ck);
    end
    sif.push_l  = 1'b1;
    sif.start_l = 1'b1;
    chk("term_busy", 32'(sif.busy),    32'd1);
    chk("term_go_l", 32'(sif.go_l),    32'd1);
    chk("term_inA",  32'(sif.inA),     32'd0);
    chk("term_done", 32'(sif.done_in), 32'd1);
    chk("term_sum",  32'(sum_acc),     32'(esum));
    @(negedge ck);
    chk_idle("after_term");
    chk("after_term_count", 32'(sif.count), 32'd0);
    chk("after_term_empty", 32'(sif.empty), 32'd1);
    model_q.delete();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_l     = 1'b0;
    sif.push_l  = 1'b1;
    sif.start_l = 1'b1;
    sif.din     = 8'd0;
    repeat (3) @(negedge ck);
    chk_idle("reset");
    chk("reset_count", 32'(sif.count), 32'd0);
    chk("reset_empty", 32'(sif.empty), 32'd1);
    chk("reset_full",  32'(sif.full),  32'd0);
    reset_l = 1'b1;

    // 3,5,7 -> sum 15
    do_push(8'd3); do_push(8'd5); do_push(8'd7);
    run_feed(1'b0);

    // start with an empty FIFO is ignored
    run_feed(1'b0);

    // nine pushes: the ninth is dropped
    for (int i = 0; i < 9; i++) do_push(8'($urandom_range(1, 255)));
    chk("full_flag", 32'(sif.full), 32'd1);
    run_feed(1'b1);

    // zero in the middle: flush, or dropped under the macro
    do_push(8'd4); do_push(8'd0); do_push(8'd6);
    run_feed(1'b0);

    // reset in the second FEED cycle
    do_push(8'd1); do_push(8'd2); do_push(8'd3);
    @(negedge ck);
    sif.start_l = 1'b0;
    @(negedge ck);
    sif.start_l = 1'b1;
    chk("rst_feed0_inA", 32'(sif.inA), 32'd1);
    @(negedge ck);
    chk("rst_feed1_inA", 32'(sif.inA), 32'd2);
    reset_l = 1'b0;
    #1;
    chk_idle("mid_reset");
    chk("mid_reset_count", 32'(sif.count), 32'd0);
    #1;
    reset_l = 1'b1;
    model_q.delete();
    do_push(8'd2);
    run_feed(1'b0);

    // two back-to-back full runs exercise pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) do_push(8'($urandom_range(1, 255)));
      run_feed(1'b1);
    end

    // random rounds, occasional zeros
    for (int r = 0; r < 25; r++) begin
      int cnt;
      cnt = $urandom_range(0, 10);
      for (int i = 0; i < cnt; i++) begin
        if ($urandom_range(0, 7) == 0) do_push(8'd0);
        else                           do_push(8'($urandom_range(1, 255)));
      end
      run_feed(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
